// File: rtl/segre_pkg.sv
// Shared core types and constants used by the fetch stage and its fetch buffer.
package segre_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned ADDR_SIZE = 32;

  // addi x0, x0, 0
  localparam logic [WORD_SIZE-1:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [ADDR_SIZE-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_RUN,
    IF_DRAIN
  } if_state_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [ADDR_SIZE-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/segre_fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush beats push.
module segre_fetch_fifo
  import segre_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rsn_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  fetch_entry_t  data_i,
  output fetch_entry_t  head_o,
  output logic          valid_o,
  output logic [CW-1:0] occ_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Guard against popping empty or pushing into a full buffer without a pop.
  always_comb begin
    do_pop  = pop_i & (cnt_q != '0);
    do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Head is exposed from registered state only; zeroed when empty.
  always_comb begin
    valid_o = (cnt_q != '0);
    occ_o   = cnt_q;
    head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  end

endmodule

// File: rtl/segre_if_stage.sv
// Instruction-fetch stage: owns the PC, issues single outstanding fetches,
// buffers responses and handles EX redirects.
// Optional macro SEGRE_IF_MISALIGN_CHECK_EN adds fetch_misaligned_o.
module segre_if_stage
  import segre_pkg::*;
#(
  parameter logic [ADDR_SIZE-1:0] BOOT_ADDR        = BOOT_ADDR_DEFAULT,
  parameter int unsigned          FETCH_FIFO_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  output logic                 imem_req_o,
  output logic [ADDR_SIZE-1:0] imem_addr_o,
  input  logic                 imem_rvalid_i,
  input  logic [WORD_SIZE-1:0] imem_rdata_i,
  input  logic                 tkbr_i,
  input  logic [ADDR_SIZE-1:0] new_pc_i,
  input  logic                 block_if_i,
  output logic [WORD_SIZE-1:0] instr_o,
  output logic [ADDR_SIZE-1:0] pc_o,
  output logic                 valid_if_o
`ifdef SEGRE_IF_MISALIGN_CHECK_EN
  ,
  output logic                 fetch_misaligned_o
`endif
);

  localparam int unsigned CW = $clog2(FETCH_FIFO_DEPTH + 1);

  if_state_e            state_q, state_d;
  logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_SIZE-1:0] req_pc_q, req_pc_d;
  logic                 outstanding_q, outstanding_d;
  logic                 drop_q, drop_d;

  logic                 push_c, pop_c, busy_c;
  logic [CW:0]          occ_next_c;
  logic [ADDR_SIZE-1:0] target_c;
  logic [CW-1:0]        occ;
  logic                 fifo_valid;
  fetch_entry_t         head, push_data;

  // Per-cycle buffer events and redirect target.
  always_comb begin
    pop_c      = fifo_valid & ~block_if_i & ~tkbr_i;
    push_c     = imem_rvalid_i & outstanding_q & ~drop_q & ~tkbr_i;
    busy_c     = outstanding_q & ~imem_rvalid_i;
    occ_next_c = {1'b0, occ} + (CW+1)'(push_c) - (CW+1)'(pop_c);
    target_c   = new_pc_i & ~ADDR_SIZE'(3);
    push_data  = '{instr: imem_rdata_i, pc: req_pc_q};
  end

  // Next-state and fetch request logic.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    imem_req_o    = 1'b0;
    imem_addr_o   = fetch_pc_q;

    // Any response retires the outstanding request; unsolicited ones change nothing.
    if (imem_rvalid_i) outstanding_d = 1'b0;

    case (state_q)
      IF_IDLE: begin
        state_d = IF_RUN;
        if (tkbr_i) fetch_pc_d = target_c;
      end
      IF_RUN: begin
        if (tkbr_i) begin
          fetch_pc_d = target_c;
          if (busy_c) begin
            drop_d  = 1'b1;
            state_d = IF_DRAIN;
          end else begin
            imem_req_o    = 1'b1;
            imem_addr_o   = target_c;
            fetch_pc_d    = target_c + ADDR_SIZE'(4);
            req_pc_d      = target_c;
            outstanding_d = 1'b1;
          end
        end else if (!busy_c && (occ_next_c < (CW+1)'(FETCH_FIFO_DEPTH))) begin
          imem_req_o    = 1'b1;
          fetch_pc_d    = fetch_pc_q + ADDR_SIZE'(4);
          req_pc_d      = fetch_pc_q;
          outstanding_d = 1'b1;
        end
      end
      IF_DRAIN: begin
        if (tkbr_i) fetch_pc_d = target_c;
        if (imem_rvalid_i) begin
          drop_d  = 1'b0;
          state_d = IF_RUN;
        end
      end
      default: state_d = IF_IDLE;
    endcase
  end

  // Fetch-control state registers.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q       <= IF_IDLE;
      fetch_pc_q    <= BOOT_ADDR;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  segre_fetch_fifo #(
    .DEPTH (FETCH_FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .flush_i (tkbr_i),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  (push_data),
    .head_o  (head),
    .valid_o (fifo_valid),
    .occ_o   (occ)
  );

  // Present buffer head to ID; NOP when nothing is buffered.
  always_comb begin
    valid_if_o = fifo_valid;
    instr_o    = fifo_valid ? head.instr : NOP_INSTR;
    pc_o       = head.pc;
  end

`ifdef SEGRE_IF_MISALIGN_CHECK_EN
  logic misaligned_q;

  // One-cycle flag for a redirect whose target had nonzero low bits.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) misaligned_q <= 1'b0;
    else        misaligned_q <= tkbr_i & (new_pc_i[1:0] != 2'b00);
  end

  assign fetch_misaligned_o = misaligned_q;
`endif

endmodule

// File: doc/segre_if_stage.md
Name: segre_if_stage

Overview:
- Instruction-fetch stage, directly upstream of the ID stage.
- Owns the PC and issues single-word fetches to instruction memory, with at most one request outstanding.
- Buffers returned words with their PCs in a small FIFO and presents the head to ID as instr/pc/valid.
- Handles branch/jump redirects from EX by flushing buffered and in-flight fetches.

Parameters:
- BOOT_ADDR, 32'h0000_0000: PC of the first fetch after reset.
- FETCH_FIFO_DEPTH, 2: entries in the fetch buffer. Must be ≥2; at 2 it sustains 1 instr/cycle with 1-cycle memory.

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  reset, asynchronous, active-low
- imem_req_o  out  1  one-cycle fetch request pulse
- imem_addr_o  out  ADDR_SIZE  fetch address, word aligned, valid with imem_req_o
- imem_rvalid_i  in  1  response for the outstanding request
- imem_rdata_i  in  WORD_SIZE  fetched instruction, valid with imem_rvalid_i
- tkbr_i  in  1  redirect request from EX (taken branch or jump)
- new_pc_i  in  ADDR_SIZE  redirect target, sampled when tkbr_i=1
- block_if_i  in  1  ID cannot accept this cycle; head is not popped
- instr_o  out  WORD_SIZE  FIFO head instruction; NOP_INSTR when empty
- pc_o  out  ADDR_SIZE  PC of the FIFO head
- valid_if_o  out  1  FIFO non-empty
- fetch_misaligned_o  out  1  only with SEGRE_IF_MISALIGN_CHECK_EN, see below

Behaviour:
- Reset (async, rsn_i=0):
  - fetch_pc=BOOT_ADDR; FIFO empty; outstanding=0; drop=0; state=IDLE.
  - Outputs: imem_req_o=0, imem_addr_o=BOOT_ADDR, valid_if_o=0, instr_o=NOP_INSTR, pc_o=0.
- FSM states:
  - IDLE: first cycle after reset release. No request. Goes to RUN.
  - RUN: normal fetching.
  - DRAIN: a redirect hit while a request was in flight; waits for that response and discards it.
- Per-cycle events:
  - pop = valid_if_o & !block_if_i & !tkbr_i
  - push = imem_rvalid_i & outstanding & !drop & !tkbr_i
  - occ_next = occ + push - pop
  - busy = outstanding & !imem_rvalid_i
- Request issue (RUN only): imem_req_o = !busy & (occ_next < FETCH_FIFO_DEPTH), with imem_addr_o=fetch_pc. On issue: outstanding←1, fetch_pc←fetch_pc+4.
  - imem_req_o depends combinationally on block_if_i and tkbr_i; this path is accepted.
- Response latency is ≥1 cycle. A request issued in the cycle its predecessor's rvalid arrives is legal.
- FIFO push stores {imem_rdata_i, PC of the request}. Head is exposed combinationally from registered FIFO state, so instr_o/pc_o/valid_if_o change only at clock edges.
- tkbr_i=1 has priority over everything:
  - FIFO cleared, so valid_if_o=0 next cycle; no pop is counted.
  - fetch_pc←{new_pc_i[ADDR_SIZE-1:2],2'b00}.
  - If busy: drop←1, state→DRAIN, no request this cycle.
  - If not busy (no outstanding, or rvalid this same cycle, which is discarded): the request for the target is issued in the same cycle with imem_addr_o=target, and fetch_pc←target+4.
- DRAIN:
  - No requests.
  - On imem_rvalid_i the data is discarded; drop←0, outstanding←0, state→RUN, and the next fetch is issued from the following cycle.
  - A further tkbr_i in DRAIN only updates fetch_pc.
- FIFO full with block_if_i held: no requests, head stable, pc_o/instr_o unchanged.
- Unsolicited rvalid (outstanding=0) is ignored.
- fetch_pc wraps modulo 2^ADDR_SIZE (32'hffff_fffc+4 → 0).
- Reset mid-operation: all state returns to reset values immediately; a late response after reset is ignored.

Optional Feature:
- Macro SEGRE_IF_MISALIGN_CHECK_EN.
- Defined: port fetch_misaligned_o exists. Registered; reset 0. It is 1 for exactly one cycle after a tkbr_i whose new_pc_i[1:0]!=0. The redirect still proceeds to the aligned address.
- Undefined: port absent; low target bits are silently forced to 0.

Decomposition:
- Add to segre_pkg:
  - if_state_e {IF_IDLE, IF_RUN, IF_DRAIN}
  - fetch_entry_t {instr, pc}
  - BOOT_ADDR_DEFAULT
- NOP_INSTR, WORD_SIZE and ADDR_SIZE are reused from segre_pkg.
- One sub-module: segre_fetch_fifo, a parameterised synchronous FIFO of fetch_entry_t with push/pop/flush/occupancy. Flush has priority over push.

Test Plan:
- Reset release, 1-cycle memory returning addr as data, block_if_i=0 → requests 0x0,0x4,0x8 on consecutive cycles from cycle 1; valid_if_o from cycle 3 with pc_o 0x0,0x4,… one per cycle.
- block_if_i=1 for 5 cycles after streaming → at most 2 entries buffered; imem_req_o stays 0 while full; head pc_o stable. Release → order preserved, no loss or duplicate.
- 3-cycle latency memory; tkbr_i=1, new_pc_i=0x100 while a request to 0x8 is outstanding → valid_if_o=0 next cycle; the 0x8 response is discarded; the next request is 0x100; the first delivered pc_o=0x100.
- tkbr_i in the same cycle as rvalid → that data is dropped; the request to the target is issued in that same cycle.
- fetch_pc=0xffff_fff8 streaming → addresses 0xffff_fff8, 0xffff_fffc, 0x0.
- With SEGRE_IF_MISALIGN_CHECK_EN, tkbr_i with new_pc_i=0x102 → fetch_misaligned_o pulses once; the fetch goes to 0x100.
